// File: rtl/clk_window_sched_if.sv
// Configuration handshake bundle for clk_window_sched: offer (valid + period/a/b),
// with ready back-pressure and a one-cycle reject pulse.
interface clk_window_sched_if #(
  parameter int CW = 6
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic [CW-1:0] cfg_period;
  logic [CW-1:0] cfg_a;
  logic [CW-1:0] cfg_b;

  modport master (
    output cfg_valid, cfg_period, cfg_a, cfg_b,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_a, cfg_b,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_window_sched.sv
// Period counter with runtime-programmable terminal count and A/B/C enable windows.
// New configurations are staged in a pending slot and only take effect at a period boundary.
module clk_window_sched #(
  parameter int CW = 6  // must be >= 5 to hold the 20/10/18 defaults
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  clk_window_sched_if.slave   cfg,
  output logic [CW-1:0]       count,
  output logic [1:0]          phase,
  output logic                en_a,
  output logic                en_b,
  output logic                en_c,
  output logic                wrap,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] act_period, act_a, act_b;
  logic [CW-1:0] pend_period, pend_a, pend_b;
  logic          pend_valid;
  logic          cfg_err_q;
  logic          at_term;
  logic          cfg_take;
  logic          cfg_legal;
  logic          apply;

  assign at_term   = (count == act_period);
  assign wrap      = (state != IDLE) && at_term;
  assign busy      = (state != IDLE);

  assign cfg_legal = (cfg.cfg_a < cfg.cfg_b) && (cfg.cfg_b <= cfg.cfg_period)
                   && (cfg.cfg_period >= CW'(2));
  assign cfg_take  = cfg.cfg_valid && !pend_valid;
  // Apply only at a period boundary (or immediately while idle) so windows never shift mid-period.
  assign apply     = pend_valid && ((state == IDLE) || wrap);

  assign cfg.cfg_ready = !pend_valid;
  assign cfg.cfg_err   = cfg_err_q;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    if (state != IDLE) begin
      en_a = (count <= act_a);
      en_b = (count > act_a) && (count < act_b);
      en_c = (count >= act_b);
    end
  end

  // NOTE: sequential state uses non-blocking assignments and the async reset clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      phase <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (start) state <= RUN;
        end
        RUN, DRAIN: begin
          if (at_term) begin
            count <= '0;
            phase <= phase + 2'd1;
          end else begin
            count <= count + CW'(1);
          end
          if (state == RUN) begin
            if (stop) state <= DRAIN;
          end else begin
            if (start)        state <= RUN;
            else if (at_term) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_period  <= CW'(20);
      act_a       <= CW'(10);
      act_b       <= CW'(18);
      pend_period <= '0;
      pend_a      <= '0;
      pend_b      <= '0;
      pend_valid  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= cfg_take && !cfg_legal;
      if (apply) begin
        act_period <= pend_period;
        act_a      <= pend_a;
        act_b      <= pend_b;
        pend_valid <= 1'b0;
      end
      // take and apply are mutually exclusive: take needs an empty slot, apply a full one
      if (cfg_take && cfg_legal) begin
        pend_period <= cfg.cfg_period;
        pend_a      <= cfg.cfg_a;
        pend_b      <= cfg.cfg_b;
        pend_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_window_sched.sv
// Directed self-checking bench for clk_window_sched: defaults, reconfig, reject,
// stop/drain, drain cancel, stop on wrap and asynchronous reset with a pending config.
module tb_clk_window_sched;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] count;
  logic [1:0]    phase;
  logic          en_a, en_b, en_c, wrap, busy;

  int tests = 0;
  int fails = 0;

  clk_window_sched_if #(.CW(CW)) cfg_bus ();

  clk_window_sched #(.CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .cfg   (cfg_bus),
    .count (count),
    .phase (phase),
    .en_a  (en_a),
    .en_b  (en_b),
    .en_c  (en_c),
    .wrap  (wrap),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs for one running cycle at counter value i under config p/a/b.
  task automatic check_win(input int i, input int p, input int a, input int b, input int ph);
    chk($sformatf("count@%0d", i), 32'(count), i);
    chk($sformatf("en_a@%0d", i), 32'(en_a), 32'(i <= a));
    chk($sformatf("en_b@%0d", i), 32'(en_b), 32'((i > a) && (i < b)));
    chk($sformatf("en_c@%0d", i), 32'(en_c), 32'(i >= b));
    chk($sformatf("wrap@%0d", i), 32'(wrap), 32'(i == p));
    chk($sformatf("phase@%0d", i), 32'(phase), ph);
    chk($sformatf("busy@%0d", i), 32'(busy), 1);
  endtask

  task automatic run_range(input int lo, input int hi, input int p, input int a, input int b,
                           input int ph);
    for (int i = lo; i <= hi; i++) begin
      check_win(i, p, a, b, ph);
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input int ph);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_phase"}, 32'(phase), ph);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
    chk({tag, "_en"}, 32'({en_a, en_b, en_c}), 0);
    chk({tag, "_ready"}, 32'(cfg_bus.cfg_ready), 1);
    chk({tag, "_err"}, 32'(cfg_bus.cfg_err), 0);
  endtask

  task automatic offer(input int p, input int a, input int b);
    cfg_bus.cfg_valid  = 1'b1;
    cfg_bus.cfg_period = CW'(p);
    cfg_bus.cfg_a      = CW'(a);
    cfg_bus.cfg_b      = CW'(b);
  endtask

  initial begin
    cfg_bus.cfg_valid  = 1'b0;
    cfg_bus.cfg_period = '0;
    cfg_bus.cfg_a      = '0;
    cfg_bus.cfg_b      = '0;

    // Reset defaults
    @(negedge clk);
    @(negedge clk);
    check_idle("in_reset", 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset", 0);

    // Default period 20/10/18
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_range(0, 20, 20, 10, 18, 0);

    // Mid-period reconfig offered at count 5, applied at the wrap at 20
    for (int i = 0; i <= 20; i++) begin
      check_win(i, 20, 10, 18, 1);
      if (i == 5) begin
        chk("ready_before_offer", 32'(cfg_bus.cfg_ready), 1);
        offer(9, 3, 6);
      end
      if (i == 6) begin
        cfg_bus.cfg_valid = 1'b0;
        chk("ready_drop", 32'(cfg_bus.cfg_ready), 0);
      end
      if (i == 20) chk("ready_low_at_wrap", 32'(cfg_bus.cfg_ready), 0);
      @(negedge clk);
    end
    chk("ready_after_apply", 32'(cfg_bus.cfg_ready), 1);
    run_range(0, 9, 9, 3, 6, 2);

    // Illegal config (a == b) rejected; windows unchanged
    check_win(0, 9, 3, 6, 3);
    offer(12, 7, 7);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    check_win(1, 9, 3, 6, 3);
    chk("err_pulse", 32'(cfg_bus.cfg_err), 1);
    chk("ready_after_err", 32'(cfg_bus.cfg_ready), 1);
    @(negedge clk);
    chk("err_single", 32'(cfg_bus.cfg_err), 0);
    run_range(2, 9, 9, 3, 6, 3);

    // Restore 20/10/18, applied at the next wrap
    check_win(0, 9, 3, 6, 0);
    offer(20, 10, 18);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    chk("restore_ready_drop", 32'(cfg_bus.cfg_ready), 0);
    run_range(1, 9, 9, 3, 6, 0);
    chk("restore_ready_rise", 32'(cfg_bus.cfg_ready), 1);

    // Stop at count 4: period completes, IDLE after the wrap
    run_range(0, 3, 20, 10, 18, 1);
    check_win(4, 20, 10, 18, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_range(5, 20, 20, 10, 18, 1);
    check_idle("stop_idle", 2);
    @(negedge clk);
    check_idle("stop_idle_hold", 2);

    // Start during DRAIN cancels the drain
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_range(0, 3, 20, 10, 18, 2);
    check_win(4, 20, 10, 18, 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_range(5, 7, 20, 10, 18, 2);
    check_win(8, 20, 10, 18, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_range(9, 20, 20, 10, 18, 2);

    // Stop in the wrap cycle: a full draining period follows
    run_range(0, 19, 20, 10, 18, 3);
    check_win(20, 20, 10, 18, 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_range(0, 20, 20, 10, 18, 0);
    check_idle("wrap_stop_idle", 1);

    // Async reset mid-run with a pending config
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_range(0, 2, 20, 10, 18, 1);
    check_win(3, 20, 10, 18, 1);
    offer(9, 3, 6);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    check_win(4, 20, 10, 18, 1);
    chk("pending_ready", 32'(cfg_bus.cfg_ready), 0);
    @(negedge clk);
    run_range(5, 12, 20, 10, 18, 1);
    check_win(13, 20, 10, 18, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset_idle", 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_range(0, 20, 20, 10, 18, 0);
    chk("post_reset_count", 32'(count), 0);
    chk("post_reset_phase", 32'(phase), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
